// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional feature macro used by this slice: WB_BYPASS_EN (early busy clear).
package riscv_wb_pkg;

  // Default widths; the top module exposes them as overridable parameters.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural zero register: never written, never busy.
  localparam int REG_ZERO = 0;

  // Writeback source identifiers, also used as the round-robin priority token.
  typedef enum logic {
    WB_SRC_EX  = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  // The other source, used when the priority token rotates.
  function automatic wb_src_e wb_src_flip(input wb_src_e src);
    return (src == WB_SRC_EX) ? WB_SRC_LSU : WB_SRC_EX;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register busy scoreboard: one bit per architectural register that is
// set when decode reserves a destination and cleared when its writeback
// retires. Produces the decode stall from the three register queries.
// Bit zero is hardwired to zero.
module wb_scoreboard
  import riscv_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Reservation (already qualified by the caller)
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  // Retirement of an outstanding write
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  // Hazard queries from the instruction in decode
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic              rs1_use,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs2_use,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_use,
  output logic              stall,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: apply the clear first so a same-edge set of the same
  // register wins; register zero is forced idle regardless of requests.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Stall on RAW (sources) and WAW (destination) hazards.
  assign stall = (rs1_use & busy_q[rs1_addr])
               | (rs2_use & busy_q[rs2_addr])
               | (rd_use  & busy_q[rd_addr]);

  assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources (EX and LSU) share the single regfile write port
// through a round-robin arbiter; the winner is captured into a registered
// output stage that drives the regfile one cycle after the handshake.
// A busy scoreboard tracks outstanding writes so decode can stall.
//
// Handshake: a source transfers in any cycle where valid and ready are both
// high. ready is a combinational function of both valids and the priority
// token; valid never depends on ready, and addr/data are held from valid
// until ready.
//
// Macro WB_BYPASS_EN: when defined, a register's busy bit is cleared on the
// handshake edge instead of the regfile-write edge, so decode sees it free
// one cycle earlier (the regfile commits on the following negedge).
module regfile_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 32  // must equal 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // EX writeback
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  // LSU writeback
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  // Register-file write port
  output logic              reg_write_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [DATA_W-1:0] data_o,
  // Decode interface
  input  logic              reserve_i,
  input  logic [ADDR_W-1:0] reserve_addr_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              rs1_use_i,
  input  logic              rs2_use_i,
  output logic              stall_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Round-robin token: names the source that wins when both request.
  wb_src_e prio_q;

  // Arbitration results
  logic              ex_grant;
  logic              lsu_grant;
  logic              handshake;
  logic              both_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_nonzero;

  // Output stage registers
  logic              reg_write_q;
  logic [ADDR_W-1:0] write_addr_q;
  logic [DATA_W-1:0] data_q;

  // Scoreboard control
  logic              sb_stall;
  logic              sb_set_en;
  logic              sb_clr_en;
  logic [ADDR_W-1:0] sb_clr_addr;
  logic [NREGS-1:0]  sb_busy;

  // Arbiter: a lone requester always wins; on contention the token decides.
  always_comb begin
    both_valid  = ex_valid_i & lsu_valid_i;
    ex_grant    = ex_valid_i  & (~lsu_valid_i | (prio_q == WB_SRC_EX));
    lsu_grant   = lsu_valid_i & (~ex_valid_i  | (prio_q == WB_SRC_LSU));
    handshake   = ex_grant | lsu_grant;
    win_addr    = ex_addr_i;
    win_data    = ex_data_i;
    if (lsu_grant) begin
      win_addr  = lsu_addr_i;
      win_data  = lsu_data_i;
    end
    win_nonzero = (win_addr != ZERO_ADDR);
  end

  assign ex_ready_o  = ex_grant;
  assign lsu_ready_o = lsu_grant;

  // Priority token: rotates only when both sources contended this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      prio_q <= WB_SRC_EX;
    end else if (both_valid) begin
      prio_q <= wb_src_flip(prio_q);
    end
  end

  // Output stage: capture the winner; x0 transfers complete but never write.
  // A reset drops any request granted in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      data_q       <= '0;
    end else begin
      reg_write_q <= handshake & win_nonzero;
      if (handshake) begin
        write_addr_q <= win_addr;
        data_q       <= win_data;
      end
    end
  end

  assign reg_write_o  = reg_write_q;
  assign write_addr_o = write_addr_q;
  assign data_o       = data_q;

  // Reservation only takes effect for a non-stalled, nonzero destination,
  // which keeps at most one outstanding write per register.
  assign sb_set_en = reserve_i & ~sb_stall & (reserve_addr_i != ZERO_ADDR);

  // Busy clear point: handshake edge with bypass, regfile-write edge without.
`ifdef WB_BYPASS_EN
  assign sb_clr_en   = handshake & win_nonzero;
  assign sb_clr_addr = win_addr;
`else
  assign sb_clr_en   = reg_write_q;
  assign sb_clr_addr = write_addr_q;
`endif

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_en   (sb_set_en),
    .set_addr (reserve_addr_i),
    .clr_en   (sb_clr_en),
    .clr_addr (sb_clr_addr),
    .rs1_addr (rs1_addr_i),
    .rs1_use  (rs1_use_i),
    .rs2_addr (rs2_addr_i),
    .rs2_use  (rs2_use_i),
    .rd_addr  (reserve_addr_i),
    .rd_use   (reserve_i),
    .stall    (sb_stall),
    .busy     (sb_busy)
  );

  assign stall_o = sb_stall;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: arbitration order, writeback
// latency, x0 handling, scoreboard hazards, same-edge set/clear and reset
// in the middle of a transfer. Honors WB_BYPASS_EN for busy-clear timing.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  // DUT signals
  logic              ex_valid_i, ex_ready_o;
  logic [ADDR_W-1:0] ex_addr_i;
  logic [DATA_W-1:0] ex_data_i;
  logic              lsu_valid_i, lsu_ready_o;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_data_i;
  logic              reg_write_o;
  logic [ADDR_W-1:0] write_addr_o;
  logic [DATA_W-1:0] data_o;
  logic              reserve_i;
  logic [ADDR_W-1:0] reserve_addr_i;
  logic [ADDR_W-1:0] rs1_addr_i, rs2_addr_i;
  logic              rs1_use_i, rs2_use_i;
  logic              stall_o;

  int checks = 0;
  int errors = 0;

  // Expected write-address sequence for the contention test
  logic [ADDR_W-1:0] exp_q[$];

  regfile_wb_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .ex_valid_i     (ex_valid_i),
    .ex_ready_o     (ex_ready_o),
    .ex_addr_i      (ex_addr_i),
    .ex_data_i      (ex_data_i),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_ready_o    (lsu_ready_o),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_data_i     (lsu_data_i),
    .reg_write_o    (reg_write_o),
    .write_addr_o   (write_addr_o),
    .data_o         (data_o),
    .reserve_i      (reserve_i),
    .reserve_addr_i (reserve_addr_i),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rs1_use_i      (rs1_use_i),
    .rs2_use_i      (rs2_use_i),
    .stall_o        (stall_o)
  );

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Scoreboard comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ex_valid_i = 1'b0; ex_addr_i = '0; ex_data_i = '0;
    lsu_valid_i = 1'b0; lsu_addr_i = '0; lsu_data_i = '0;
    reserve_i = 1'b0; reserve_addr_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0; rs1_use_i = 1'b0; rs2_use_i = 1'b0;
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;

    // Reset state
    rs1_addr_i = 5'd5; rs1_use_i = 1'b1; rs2_addr_i = 5'd31; rs2_use_i = 1'b1;
    settle();
    check("rst_reg_write", 32'(reg_write_o), 32'd0);
    check("rst_write_addr", 32'(write_addr_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rs1_use_i = 1'b0; rs2_use_i = 1'b0;

    // EX alone
    ex_valid_i = 1'b1; ex_addr_i = 5'd5; ex_data_i = 32'hDEADBEEF;
    settle();
    check("ex_alone_ready", 32'(ex_ready_o), 32'd1);
    check("ex_alone_lsu_ready", 32'(lsu_ready_o), 32'd0);
    tick();
    ex_valid_i = 1'b0;
    settle();
    check("ex_alone_we", 32'(reg_write_o), 32'd1);
    check("ex_alone_addr", 32'(write_addr_o), 32'd5);
    check("ex_alone_data", data_o, 32'hDEADBEEF);
    tick();
    check("idle_we", 32'(reg_write_o), 32'd0);

    // Contention: EX addr 1, LSU addr 2 for four cycles -> EX, LSU, EX, LSU
    ex_valid_i = 1'b1; ex_addr_i = 5'd1; ex_data_i = 32'h11;
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd2; lsu_data_i = 32'h22;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("rr_ex_ready_%0d", i), 32'(ex_ready_o), ((i % 2) == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_lsu_ready_%0d", i), 32'(lsu_ready_o), ((i % 2) == 0) ? 32'd0 : 32'd1);
      exp_q.push_back(((i % 2) == 0) ? 5'd1 : 5'd2);
      tick();
      if (i == 3) begin
        ex_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
      end
      check($sformatf("rr_we_%0d", i), 32'(reg_write_o), 32'd1);
      check($sformatf("rr_addr_%0d", i), 32'(write_addr_o), 32'(exp_q.pop_front()));
    end
    settle();
    check("rr_data_last", data_o, 32'h22);
    tick();
    check("rr_idle_we", 32'(reg_write_o), 32'd0);

    // x0 writeback and x0 reservation
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd0; lsu_data_i = 32'h1234;
    settle();
    check("x0_lsu_ready", 32'(lsu_ready_o), 32'd1);
    tick();
    lsu_valid_i = 1'b0;
    reserve_i = 1'b1; reserve_addr_i = 5'd0;
    settle();
    check("x0_we", 32'(reg_write_o), 32'd0);
    check("x0_reserve_stall", 32'(stall_o), 32'd0);
    tick();
    reserve_i = 1'b0;
    rs1_addr_i = 5'd0; rs1_use_i = 1'b1;
    settle();
    check("x0_not_busy", 32'(stall_o), 32'd0);
    rs1_use_i = 1'b0;

    // Hazard on x7
    reserve_i = 1'b1; reserve_addr_i = 5'd7;
    settle();
    check("rsv7_stall", 32'(stall_o), 32'd0);
    tick();
    reserve_i = 1'b0;
    rs1_addr_i = 5'd7; rs1_use_i = 1'b1;
    settle();
    check("raw7_stall", 32'(stall_o), 32'd1);
    reserve_i = 1'b1; reserve_addr_i = 5'd8;  // suppressed by stall
    settle();
    check("rsv8_suppressed_stall", 32'(stall_o), 32'd1);
    tick();
    rs1_use_i = 1'b0;
    reserve_i = 1'b1; reserve_addr_i = 5'd7;
    settle();
    check("waw7_stall", 32'(stall_o), 32'd1);
    tick();
    reserve_i = 1'b0;
    rs1_addr_i = 5'd7; rs1_use_i = 1'b1;
    ex_valid_i = 1'b1; ex_addr_i = 5'd7; ex_data_i = 32'h77;
    settle();
    check("wb7_ready", 32'(ex_ready_o), 32'd1);
    check("wb7_stall_n", 32'(stall_o), 32'd1);
    tick();
    ex_valid_i = 1'b0;
    settle();
    check("wb7_we", 32'(reg_write_o), 32'd1);
    check("wb7_addr", 32'(write_addr_o), 32'd7);
`ifdef WB_BYPASS_EN
    check("wb7_stall_n1", 32'(stall_o), 32'd0);
`else
    check("wb7_stall_n1", 32'(stall_o), 32'd1);
`endif
    tick();
    check("wb7_stall_n2", 32'(stall_o), 32'd0);
    rs1_addr_i = 5'd8;
    settle();
    check("x8_not_busy", 32'(stall_o), 32'd0);
    rs1_use_i = 1'b0;

    // Same-edge clear and reserve of x9: set wins
    ex_valid_i = 1'b1; ex_addr_i = 5'd9; ex_data_i = 32'h99;
`ifdef WB_BYPASS_EN
    reserve_i = 1'b1; reserve_addr_i = 5'd9;
    settle();
    check("same9_reserve_stall", 32'(stall_o), 32'd0);
`endif
    tick();
    ex_valid_i = 1'b0;
`ifdef WB_BYPASS_EN
    reserve_i = 1'b0;
`else
    reserve_i = 1'b1; reserve_addr_i = 5'd9;
    settle();
    check("same9_reserve_stall", 32'(stall_o), 32'd0);
`endif
    settle();
    check("same9_we", 32'(reg_write_o), 32'd1);
    check("same9_addr", 32'(write_addr_o), 32'd9);
    tick();
    reserve_i = 1'b0;
    rs1_addr_i = 5'd9; rs1_use_i = 1'b1;
    settle();
    check("same9_busy", 32'(stall_o), 32'd1);
    rs1_use_i = 1'b0;

    // Mid-operation reset
    reserve_i = 1'b1; reserve_addr_i = 5'd10;
    settle();
    check("rsv10_stall", 32'(stall_o), 32'd0);
    tick();
    reserve_i = 1'b0;
    ex_valid_i = 1'b1; ex_addr_i = 5'd1; ex_data_i = 32'h11;
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd2; lsu_data_i = 32'h22;
    settle();
    check("pre_rst_ex_grant", 32'(ex_ready_o), 32'd1);
    tick();
    lsu_valid_i = 1'b0;
    ex_addr_i = 5'd3; ex_data_i = 32'h33;
    rst_i = 1'b0;
    settle();
    check("pre_rst_hs3", 32'(ex_ready_o), 32'd1);
    tick();
    rst_i = 1'b1;
    ex_valid_i = 1'b0;
    settle();
    check("midrst_we", 32'(reg_write_o), 32'd0);
    check("midrst_addr", 32'(write_addr_o), 32'd0);
    check("midrst_data", data_o, 32'd0);
    rs1_addr_i = 5'd9; rs1_use_i = 1'b1;
    rs2_addr_i = 5'd10; rs2_use_i = 1'b1;
    settle();
    check("midrst_busy_clear", 32'(stall_o), 32'd0);
    rs1_use_i = 1'b0; rs2_use_i = 1'b0;
    ex_valid_i = 1'b1; lsu_valid_i = 1'b1;
    settle();
    check("midrst_prio_ex", 32'(ex_ready_o), 32'd1);
    check("midrst_prio_lsu", 32'(lsu_ready_o), 32'd0);
    tick();
    ex_valid_i = 1'b0; lsu_valid_i = 1'b0;
    tick();

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
